// File: rtl/ppwm_prog_mem.sv
// Program store for the PWM executor: bit-serial loader writes words, fetch port reads mem[pc_i] combinationally.
// Optional readback of the previous program while loading: define PPWM_PROG_READBACK_EN.
module ppwm_prog_mem #(
    parameter int INSTR_WIDTH = 7,
    parameter int PC_WIDTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_en_i,
    input  logic                   bit_valid_i,
    input  logic                   bit_i,
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   loading_o,
    output logic                   done_o,
    output logic                   rb_bit_o
);
    localparam int DEPTH = 2 ** PC_WIDTH;
    localparam int CNT_W = $clog2(INSTR_WIDTH);
    localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(INSTR_WIDTH - 1);
    localparam logic [PC_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
    logic [PC_WIDTH-1:0]    r_wr_addr;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [INSTR_WIDTH-2:0] r_shift;
    logic                   w_start;
    logic                   w_accept;
    logic                   w_commit;
    logic [INSTR_WIDTH-1:0] w_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Dropping load_en_i takes priority over a bit offered in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        loading_o    = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            StIdle: begin
                if (load_en_i) begin
                    w_state_next = StLoad;
                    w_start      = 1'b1;
                end
            end
            StLoad: begin
                loading_o = 1'b1;
                if (!load_en_i) begin
                    w_state_next = StIdle;
                end else if (bit_valid_i) begin
                    w_accept = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_commit = 1'b1;
                        if (r_wr_addr == LAST_ADDR) begin
                            w_state_next = StDone;
                        end
                    end
                end
            end
            StDone: begin
                done_o = 1'b1;
                if (!load_en_i) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_word = {r_shift, bit_i};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_start) begin
            r_wr_addr <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            if (w_commit) begin
                r_bit_cnt <= '0;
                r_wr_addr <= r_wr_addr + 1'b1;
            end else begin
                r_shift   <= {r_shift[INSTR_WIDTH-3:0], bit_i};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_wr_addr] <= w_word;
        end
    end

    // Register-based store so the executor sees the word at pc_i in the same cycle.
    assign instr_o = r_mem[pc_i];

`ifdef PPWM_PROG_READBACK_EN
    logic [INSTR_WIDTH-1:0] r_rb;
    logic [PC_WIDTH-1:0]    w_rb_addr;

    assign w_rb_addr = r_wr_addr + 1'b1;

    // Reload on commit grabs the next word before the new program overwrites it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rb <= '0;
        end else if (w_start) begin
            r_rb <= r_mem[0];
        end else if (w_commit) begin
            r_rb <= r_mem[w_rb_addr];
        end else if (w_accept) begin
            r_rb <= {r_rb[INSTR_WIDTH-2:0], 1'b0};
        end
    end

    assign rb_bit_o = (r_state == StLoad) && r_rb[INSTR_WIDTH-1];
`else
    assign rb_bit_o = 1'b0;
`endif

endmodule

// File: tb/tb_ppwm_prog_mem.sv
// Scoreboard bench for ppwm_prog_mem: the driver queues expectations from a word-level program model,
// a negedge monitor pops and compares them against the outputs.
module tb_ppwm_prog_mem;
    localparam int W  = 7;
    localparam int PW = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_en_i = 1'b0;
    logic          bit_valid_i = 1'b0;
    logic          bit_i = 1'b0;
    logic [PW-1:0] pc_i = '0;
    logic [W-1:0]  instr_o;
    logic          loading_o;
    logic          done_o;
    logic          rb_bit_o;

    always #5 clk = ~clk;

    ppwm_prog_mem #(.INSTR_WIDTH(W), .PC_WIDTH(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en_i  (load_en_i),
        .bit_valid_i(bit_valid_i),
        .bit_i      (bit_i),
        .pc_i       (pc_i),
        .instr_o    (instr_o),
        .loading_o  (loading_o),
        .done_o     (done_o),
        .rb_bit_o   (rb_bit_o)
    );

    typedef enum int {K_INSTR, K_LOADING, K_DONE, K_RB} kind_t;
    typedef struct {
        kind_t        kind;
        logic [W-1:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   finished = 1'b0;

    // Program model: the stored words plus where the session is in the incoming word stream.
    logic [W-1:0] ref_mem [D];
    bit           m_loading;
    bit           m_done;
    int           m_addr;
    int           m_bits;
    logic [W-1:0] m_word;

    always @(negedge clk) begin : monitor
        exp_t         e;
        logic [W-1:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_INSTR:   act = instr_o;
                K_LOADING: act = W'(loading_o);
                K_DONE:    act = W'(done_o);
                default:   act = W'(rb_bit_o);
            endcase
            n_checks++;
            if (act === e.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s pc=%0d got=%h exp=%h t=%0t", e.kind.name(), pc_i, act, e.exp, $time);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        if (!finished) begin
            $display("FAIL timeout: stimulus did not complete t=%0t", $time);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(kind_t k, logic [W-1:0] v);
        sb.push_back('{kind: k, exp: v});
    endtask

    // The bit the host should see next is the not-yet-overwritten old word's next MSB.
    function automatic logic [W-1:0] rb_exp();
`ifdef PPWM_PROG_READBACK_EN
        if (m_loading) return W'(ref_mem[m_addr][W-1-m_bits]);
`endif
        return '0;
    endfunction

    task automatic chk_status();
        push(K_LOADING, W'(m_loading));
        push(K_DONE, W'(m_done));
        push(K_RB, rb_exp());
    endtask

    task automatic chk_reset_state();
        n_checks++;
        if (loading_o === 1'b0 && done_o === 1'b0 && rb_bit_o === 1'b0 && instr_o === '0) begin
            n_pass++;
        end else begin
            $display("FAIL reset state loading=%b done=%b rb=%b instr=%h t=%0t",
                     loading_o, done_o, rb_bit_o, instr_o, $time);
        end
    endtask

    task automatic drive_bit(logic v, logic b);
        bit_valid_i = v;
        bit_i       = b;
        chk_status();
        if (v && m_loading) begin
            m_word = {m_word[W-2:0], b};
            m_bits++;
            if (m_bits == W) begin
                ref_mem[m_addr] = m_word;
                m_bits = 0;
                m_addr++;
                if (m_addr == D) begin
                    m_addr    = 0;
                    m_loading = 0;
                    m_done    = 1;
                end
            end
        end
        tick();
        bit_valid_i = 1'b0;
    endtask

    task automatic set_load(logic v);
        load_en_i = v;
        chk_status();
        tick();
        if (v) begin
            if (!m_loading && !m_done) begin
                m_loading = 1;
                m_addr    = 0;
                m_bits    = 0;
                m_word    = '0;
            end
        end else begin
            m_loading = 0;
            m_done    = 0;
        end
    endtask

    // Fetches the target address across the commit: old word in the commit cycle, new word after.
    task automatic load_word(logic [W-1:0] w, int gap);
        int a;
        bit commits;
        a       = m_addr;
        commits = m_loading;
        pc_i    = PW'(a);
        for (int j = W - 1; j >= 0; j--) begin
            while (int'($urandom_range(99)) < gap) drive_bit(1'b0, 1'($urandom));
            if (j == 0) push(K_INSTR, ref_mem[a]);
            drive_bit(1'b1, w[j]);
        end
        if (commits) begin
            push(K_INSTR, ref_mem[a]);
            chk_status();
            tick();
        end
    endtask

    task automatic load_prog(int mode, int gap);
        for (int k = 0; k < D; k++) begin
            logic [W-1:0] w;
            if (mode == 0)      w = W'(k + 16);
            else if (mode == 1) w = '0;
            else                w = W'($urandom);
            load_word(w, gap);
        end
    endtask

    task automatic sweep();
        for (int p = 0; p < D; p++) begin
            pc_i = PW'(p);
            push(K_INSTR, ref_mem[p]);
            chk_status();
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        load_en_i   = 1'b0;
        bit_valid_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        m_loading = 0;
        m_done    = 0;
        m_addr    = 0;
        m_bits    = 0;
        m_word    = '0;
    endtask

    initial begin
        do_reset();
        chk_reset_state();
        sweep();

        // Full load of word k = k + 0x10, then bits while done must not disturb memory.
        set_load(1'b1);
        load_prog(0, 0);
        pc_i = PW'(5);
        push(K_INSTR, 7'h15);
        chk_status();
        tick();
        for (int i = 0; i < 14; i++) drive_bit(1'b1, 1'($urandom));
        sweep();
        set_load(1'b0);

        // Abort after two words and three bits.
        set_load(1'b1);
        load_word(7'h2A, 0);
        load_word(7'h55, 0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'($urandom));
        set_load(1'b0);
        pc_i = PW'(2);
        push(K_INSTR, 7'h12);
        chk_status();
        tick();
        sweep();

        // Random program with random bit_valid_i gaps.
        set_load(1'b1);
        load_prog(2, 40);
        sweep();
        set_load(1'b0);

        // Reset in the middle of a session, then a fresh session from address 0.
        set_load(1'b1);
        for (int i = 0; i < 40; i++) drive_bit(1'b1, 1'($urandom));
        do_reset();
        chk_reset_state();
        sweep();
        set_load(1'b1);
        load_word(7'h33, 0);
        set_load(1'b0);
        sweep();

        // Known program followed by an all-zero program streams the old words back.
        set_load(1'b1);
        load_prog(0, 0);
        set_load(1'b0);
        set_load(1'b1);
        load_prog(1, 20);
        set_load(1'b0);
        sweep();

        tick();
        tick();
        finished = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
